// File: rtl/transmitter_controller.sv
// Transmitter control FSM: IDLE -> LOAD -> XMIT -> DONE, outputs decoded from registered state.
// Optional XMIT timeout abort is compiled in when TXC_TIMEOUT_EN is defined.
module transmitter_controller #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic serIn,
    input  logic Cout,
    output logic ld_counter,
    output logic dec_counter,
    output logic tri_en,
    output logic busy,
    output logic done,
    output logic err
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        XMIT = 2'b10,
        DONE = 2'b11
    } state_t;

    state_t state;
    state_t state_next;
    logic   timeout;

`ifdef TXC_TIMEOUT_EN
    logic [7:0] xmit_cnt;
    logic       err_q;

    // Counter holds zero outside XMIT, so it reads 0 in the first XMIT cycle.
    assign timeout = (state == XMIT) && (xmit_cnt == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            xmit_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= timeout && !Cout;
            if (state == XMIT)
                xmit_cnt <= xmit_cnt + 8'd1;
            else
                xmit_cnt <= '0;
        end
    end

    assign err = err_q;
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next  = state;
        ld_counter  = 1'b0;
        dec_counter = 1'b0;
        tri_en      = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (state)
            IDLE: begin
                if (en && !serIn)
                    state_next = LOAD;
            end
            LOAD: begin
                ld_counter = 1'b1;
                busy       = 1'b1;
                state_next = XMIT;
            end
            XMIT: begin
                dec_counter = 1'b1;
                tri_en      = 1'b1;
                busy        = 1'b1;
                // Cout completing the frame wins over a simultaneous timeout.
                if (Cout)
                    state_next = DONE;
                else if (timeout)
                    state_next = IDLE;
            end
            DONE: begin
                done       = 1'b1;
                busy       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_transmitter_controller.sv
// Scoreboard bench for transmitter_controller: per-cycle expected output vectors
// {ld_counter, dec_counter, tri_en, busy, done, err} queued with stimulus, compared after each edge.
module tb_transmitter_controller;

    localparam logic [5:0] O_IDLE = 6'b000000;
    localparam logic [5:0] O_LOAD = 6'b100100;
    localparam logic [5:0] O_XMIT = 6'b011100;
    localparam logic [5:0] O_DONE = 6'b000110;
    localparam logic [5:0] O_ERR  = 6'b000001;

    typedef struct {
        logic       rst;
        logic       en;
        logic       ser;
        logic       cout;
        logic [5:0] exp;
    } step_t;

    logic clk = 1'b0;
    logic rst, en, serIn, Cout;
    logic ld_counter, dec_counter, tri_en, busy, done, err;

    int errors = 0;
    int checks = 0;
    logic [5:0] exp_q[$];

    transmitter_controller #(.TIMEOUT_CYCLES(255)) dut (
        .clk(clk), .rst(rst), .en(en), .serIn(serIn), .Cout(Cout),
        .ld_counter(ld_counter), .dec_counter(dec_counter), .tri_en(tri_en),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] outv();
        return {ld_counter, dec_counter, tri_en, busy, done, err};
    endfunction

    function automatic step_t mk(logic r, logic e, logic s, logic c, logic [5:0] x);
        step_t t;
        t.rst = r; t.en = e; t.ser = s; t.cout = c; t.exp = x;
        return t;
    endfunction

    task automatic test_reset();
        step_t plan[$];
        logic [5:0] got, want;
        plan.push_back(mk(1, 1, 0, 0, O_IDLE));
        plan.push_back(mk(1, 1, 0, 0, O_IDLE));
        plan.push_back(mk(0, 1, 1, 0, O_IDLE));
        foreach (plan[i]) begin
            rst = plan[i].rst; en = plan[i].en; serIn = plan[i].ser; Cout = plan[i].cout;
            exp_q.push_back(plan[i].exp);
            @(posedge clk); #1;
            got = outv(); want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL reset step %0d: got=%b want=%b", i, got, want);
            end
        end
    endtask

    task automatic test_normal_frame();
        step_t plan[$];
        logic [5:0] got, want;
        int n_busy = 0, n_tri = 0, n_done = 0, n_ld = 0;
        plan.push_back(mk(0, 1, 0, 0, O_LOAD));
        plan.push_back(mk(0, 1, 1, 0, O_XMIT));
        for (int k = 0; k < 9; k++) plan.push_back(mk(0, 1, 1, 0, O_XMIT));
        plan.push_back(mk(0, 1, 1, 1, O_DONE));
        plan.push_back(mk(0, 1, 1, 0, O_IDLE));
        foreach (plan[i]) begin
            rst = plan[i].rst; en = plan[i].en; serIn = plan[i].ser; Cout = plan[i].cout;
            exp_q.push_back(plan[i].exp);
            if (i == 0) begin
                // start bit applied but not yet clocked: outputs must not react
                #1;
                checks++;
                if (outv() !== O_IDLE) begin
                    errors++;
                    $display("FAIL comb_path: got=%b want=%b", outv(), O_IDLE);
                end
            end
            @(posedge clk); #1;
            got = outv(); want = exp_q.pop_front();
            n_busy += int'(busy); n_tri += int'(tri_en); n_done += int'(done); n_ld += int'(ld_counter);
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL normal step %0d: got=%b want=%b", i, got, want);
            end
        end
        checks++;
        if (n_busy != 12) begin errors++; $display("FAIL normal busy_cycles: got=%0d want=12", n_busy); end
        checks++;
        if (n_tri != 10) begin errors++; $display("FAIL normal tri_cycles: got=%0d want=10", n_tri); end
        checks++;
        if (n_done != 1 || n_ld != 1) begin
            errors++;
            $display("FAIL normal pulses: done=%0d ld=%0d want 1 and 1", n_done, n_ld);
        end
    endtask

    task automatic test_zero_count();
        step_t plan[$];
        logic [5:0] got, want;
        plan.push_back(mk(0, 1, 1, 1, O_IDLE));
        plan.push_back(mk(0, 1, 0, 1, O_LOAD));
        plan.push_back(mk(0, 1, 1, 1, O_XMIT));
        plan.push_back(mk(0, 1, 1, 1, O_DONE));
        plan.push_back(mk(0, 1, 1, 1, O_IDLE));
        foreach (plan[i]) begin
            rst = plan[i].rst; en = plan[i].en; serIn = plan[i].ser; Cout = plan[i].cout;
            exp_q.push_back(plan[i].exp);
            @(posedge clk); #1;
            got = outv(); want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL zero_count step %0d: got=%b want=%b", i, got, want);
            end
        end
    endtask

    task automatic test_disabled();
        step_t plan[$];
        logic [5:0] got, want;
        for (int k = 0; k < 20; k++) plan.push_back(mk(0, 0, 0, 0, O_IDLE));
        plan.push_back(mk(0, 1, 0, 0, O_LOAD));
        plan.push_back(mk(0, 1, 1, 1, O_XMIT));
        plan.push_back(mk(0, 1, 1, 1, O_DONE));
        plan.push_back(mk(0, 1, 1, 0, O_IDLE));
        foreach (plan[i]) begin
            rst = plan[i].rst; en = plan[i].en; serIn = plan[i].ser; Cout = plan[i].cout;
            exp_q.push_back(plan[i].exp);
            @(posedge clk); #1;
            got = outv(); want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL disabled step %0d: got=%b want=%b", i, got, want);
            end
        end
    endtask

    task automatic test_en_drop();
        step_t plan[$];
        logic [5:0] got, want;
        plan.push_back(mk(0, 1, 0, 0, O_LOAD));
        plan.push_back(mk(0, 0, 0, 0, O_XMIT));
        plan.push_back(mk(0, 0, 0, 0, O_XMIT));
        plan.push_back(mk(0, 0, 0, 1, O_DONE));
        plan.push_back(mk(0, 0, 0, 0, O_IDLE));
        plan.push_back(mk(0, 0, 0, 0, O_IDLE));
        foreach (plan[i]) begin
            rst = plan[i].rst; en = plan[i].en; serIn = plan[i].ser; Cout = plan[i].cout;
            exp_q.push_back(plan[i].exp);
            @(posedge clk); #1;
            got = outv(); want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL en_drop step %0d: got=%b want=%b", i, got, want);
            end
        end
    endtask

    task automatic test_back_to_back();
        step_t plan[$];
        logic [5:0] got, want;
        // serIn held low through DONE: next LOAD only after one IDLE cycle
        for (int k = 0; k < 2; k++) begin
            plan.push_back(mk(0, 1, 0, 1, O_LOAD));
            plan.push_back(mk(0, 1, 0, 1, O_XMIT));
            plan.push_back(mk(0, 1, 0, 1, O_DONE));
            plan.push_back(mk(0, 1, 0, 1, O_IDLE));
        end
        plan.push_back(mk(0, 1, 1, 0, O_IDLE));
        foreach (plan[i]) begin
            rst = plan[i].rst; en = plan[i].en; serIn = plan[i].ser; Cout = plan[i].cout;
            exp_q.push_back(plan[i].exp);
            @(posedge clk); #1;
            got = outv(); want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL back_to_back step %0d: got=%b want=%b", i, got, want);
            end
        end
    endtask

    task automatic test_mid_reset();
        step_t plan[$];
        logic [5:0] got, want;
        plan.push_back(mk(0, 1, 0, 0, O_LOAD));
        plan.push_back(mk(0, 1, 1, 0, O_XMIT));
        plan.push_back(mk(0, 1, 1, 0, O_XMIT));
        plan.push_back(mk(0, 1, 1, 0, O_XMIT));
        plan.push_back(mk(1, 1, 1, 1, O_IDLE));
        plan.push_back(mk(0, 1, 1, 1, O_IDLE));
        plan.push_back(mk(0, 1, 1, 0, O_IDLE));
        foreach (plan[i]) begin
            rst = plan[i].rst; en = plan[i].en; serIn = plan[i].ser; Cout = plan[i].cout;
            exp_q.push_back(plan[i].exp);
            @(posedge clk); #1;
            got = outv(); want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL mid_reset step %0d: got=%b want=%b", i, got, want);
            end
        end
    endtask

    task automatic test_timeout();
        step_t plan[$];
        logic [5:0] got, want;
`ifdef TXC_TIMEOUT_EN
        // 255 XMIT cycles with Cout low -> err pulse in IDLE
        plan.push_back(mk(0, 1, 0, 0, O_LOAD));
        plan.push_back(mk(0, 1, 1, 0, O_XMIT));
        for (int k = 0; k < 254; k++) plan.push_back(mk(0, 1, 1, 0, O_XMIT));
        plan.push_back(mk(0, 1, 1, 0, O_ERR));
        plan.push_back(mk(0, 1, 1, 0, O_IDLE));
        // Cout on the timeout edge takes priority
        plan.push_back(mk(0, 1, 0, 0, O_LOAD));
        plan.push_back(mk(0, 1, 1, 0, O_XMIT));
        for (int k = 0; k < 254; k++) plan.push_back(mk(0, 1, 1, 0, O_XMIT));
        plan.push_back(mk(0, 1, 1, 1, O_DONE));
        plan.push_back(mk(0, 1, 1, 0, O_IDLE));
`else
        plan.push_back(mk(0, 1, 0, 0, O_LOAD));
        plan.push_back(mk(0, 1, 1, 0, O_XMIT));
        for (int k = 0; k < 300; k++) plan.push_back(mk(0, 1, 1, 0, O_XMIT));
        plan.push_back(mk(0, 1, 1, 1, O_DONE));
        plan.push_back(mk(0, 1, 1, 0, O_IDLE));
`endif
        foreach (plan[i]) begin
            rst = plan[i].rst; en = plan[i].en; serIn = plan[i].ser; Cout = plan[i].cout;
            exp_q.push_back(plan[i].exp);
            @(posedge clk); #1;
            got = outv(); want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL timeout step %0d: got=%b want=%b", i, got, want);
            end
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; serIn = 1'b0; Cout = 1'b0;
        test_reset();
        test_normal_frame();
        test_zero_count();
        test_disabled();
        test_en_drop();
        test_back_to_back();
        test_mid_reset();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
